// File: rtl/ahbl_cmd_master_if.sv
// ahbl_cmd_master_if: command / write-data / response handshakes plus the
// AHB-Lite initiator signals of ahbl_cmd_master, bundled as one interface.
// The master modport is the block's own view; slave is the environment's view
// (command source, response sink and the AHB-Lite slave).
interface ahbl_cmd_master_if #(
  parameter int AHB_AWIDTH = 32,
  parameter int LEN_W      = 4
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [AHB_AWIDTH-1:0] cmd_addr;
  logic [1:0]            cmd_size;
  logic [LEN_W-1:0]      cmd_len;
  // write-data channel
  logic                  wr_valid;
  logic                  wr_ready;
  logic [31:0]           wr_data;
  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_last;
  logic                  busy;
  // AHB-Lite
  logic [AHB_AWIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [31:0]           HWDATA;
  logic [31:0]           HRDATA;
  logic                  HREADY;
  logic [1:0]            HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
    input  wr_valid, wr_data, rsp_ready,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready, wr_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_len,
    output wr_valid, wr_data, rsp_ready,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready, wr_ready, rsp_valid, rsp_rdata, rsp_err, rsp_last, busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
  );
endinterface

// File: rtl/ahbl_cmd_master.sv
// ahbl_cmd_master: turns command/write-data/response handshakes into AHB-Lite
// single (NONSEQ/SINGLE) transfers, one outstanding at a time, 1..16 beats per
// command with an incrementing, wrapping address.
// Optional feature macro AHBL_CMD_MASTER_TIMEOUT_EN: wait-state timeout after
// TIMEOUT_CYCLES consecutive HREADY=0 cycles, plus a sticky timeout_flag port.
module ahbl_cmd_master #(
  parameter int AHB_AWIDTH = 32,
  parameter int AHB_DWIDTH = 32,
  parameter int LEN_W      = 4
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic HCLK,
  input  logic HRESETN,
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  output logic timeout_flag,
`endif
  ahbl_cmd_master_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WDATA = 3'd1;
  localparam logic [2:0] ST_ADDR  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  localparam logic [AHB_AWIDTH-1:0] ADDR_ONE = AHB_AWIDTH'(1'b1);
  localparam logic [LEN_W-1:0]      LEN_ONE  = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0]      LEN_ZERO = LEN_W'(1'b0);

  // Illegal size or an address not aligned to the transfer size.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = a[0];
      2'd2:    bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Copy right-justified write data onto every byte lane of its size.
  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Pull the addressed lane out of HRDATA, right-justified and zero-extended.
  function automatic logic [31:0] lane_extract(input logic [1:0] size, input logic [1:0] a,
                                               input logic [31:0] d);
    logic [31:0] sh;
    logic [31:0] r;
    sh = d >> {a, 3'b000};
    case (size)
      2'd0:    r = {24'h000000, sh[7:0]};
      2'd1:    r = {16'h0000, sh[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [AHB_AWIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  write_q, write_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic [AHB_DWIDTH-1:0] wdata_q, wdata_d;
  logic [AHB_DWIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  cmd_ready_q;
  logic                  wr_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_last_q;
  logic                  busy_q;
  logic [1:0]            htrans_q;

  logic                  timeout_s;
  logic                  unused_hresp_s;

  assign unused_hresp_s = bus.HRESP[1];

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1'b1);

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_flag_q;
  logic            stall_s;

  assign stall_s   = ((state_q == ST_ADDR) || (state_q == ST_DATA)) && !bus.HREADY;
  assign timeout_s = stall_s && (to_cnt_q == TO_LAST);

  // Count consecutive stalled bus cycles; remember any timeout until reset.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      to_cnt_q       <= {TO_W{1'b0}};
      timeout_flag_q <= 1'b0;
    end else begin
      if (stall_s && !timeout_s) begin
        to_cnt_q <= to_cnt_q + TO_ONE;
      end else begin
        to_cnt_q <= {TO_W{1'b0}};
      end
      if (timeout_s) begin
        timeout_flag_q <= 1'b1;
      end else begin
        timeout_flag_q <= timeout_flag_q;
      end
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and datapath decisions for one beat at a time.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d  = bus.cmd_addr;
          size_d  = bus.cmd_size;
          write_d = bus.cmd_write;
          rem_d   = bus.cmd_len;
          rdata_d = {AHB_DWIDTH{1'b0}};
          if (misaligned(bus.cmd_size, bus.cmd_addr[1:0])) begin
            // rejected without touching the bus: single error response
            err_d   = 1'b1;
            rem_d   = LEN_ZERO;
            state_d = ST_RESP;
          end else if (bus.cmd_write) begin
            err_d   = 1'b0;
            state_d = ST_WDATA;
          end else begin
            err_d   = 1'b0;
            state_d = ST_ADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (bus.wr_valid && wr_ready_q) begin
          wdata_d = lane_replicate(size_q, bus.wr_data);
          state_d = ST_ADDR;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d = ST_DATA;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = {AHB_DWIDTH{1'b0}};
          state_d = ST_RESP;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        // HREADY=0 with HRESP=ERROR is just the first error cycle: keep waiting
        if (bus.HREADY) begin
          err_d   = bus.HRESP[0];
          rdata_d = write_q ? {AHB_DWIDTH{1'b0}} : lane_extract(size_q, addr_q[1:0], bus.HRDATA);
          state_d = ST_RESP;
        end else if (timeout_s) begin
          err_d   = 1'b1;
          rdata_d = {AHB_DWIDTH{1'b0}};
          state_d = ST_RESP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready && rsp_valid_q) begin
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + (ADDR_ONE << size_q);
            rem_d   = rem_q - LEN_ONE;
            state_d = write_q ? ST_WDATA : ST_ADDR;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and per-command datapath registers.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q <= ST_IDLE;
      addr_q  <= {AHB_AWIDTH{1'b0}};
      size_q  <= 2'b00;
      write_q <= 1'b0;
      rem_q   <= LEN_ZERO;
      wdata_q <= {AHB_DWIDTH{1'b0}};
      rdata_q <= {AHB_DWIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      rem_q   <= rem_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and HTRANS outputs registered from the next state, so they
  // line up with state_q and drop to zero the instant HRESETN asserts.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      cmd_ready_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      htrans_q    <= 2'b00;
    end else begin
      cmd_ready_q <= (state_d == ST_IDLE);
      wr_ready_q  <= (state_d == ST_WDATA);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_last_q  <= (state_d == ST_RESP) && ((rem_d == LEN_ZERO) || err_d);
      busy_q      <= (state_d != ST_IDLE);
      htrans_q    <= (state_d == ST_ADDR) ? 2'b10 : 2'b00;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.busy      = busy_q;
  assign bus.HADDR     = addr_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWRITE    = write_q;
  assign bus.HSIZE     = {1'b0, size_q};
  assign bus.HBURST    = 3'b000;
  assign bus.HWDATA    = wdata_q;

endmodule

// File: tb/tb_ahbl_cmd_master.sv
// tb_ahbl_cmd_master: directed test-plan cases plus randomized commands, each
// checked beat by beat against an arithmetic model of the expected transfers.
`timescale 1ns/1ps
module tb_ahbl_cmd_master;

  logic HCLK = 1'b0;
  logic HRESETN;
  always #5 HCLK = ~HCLK;

  ahbl_cmd_master_if #(.AHB_AWIDTH(32), .LEN_W(4)) bus ();

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
  localparam int TO = 8;
  logic timeout_flag;
  ahbl_cmd_master #(.AHB_AWIDTH(32), .AHB_DWIDTH(32), .LEN_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .timeout_flag(timeout_flag), .bus(bus));
`else
  ahbl_cmd_master #(.AHB_AWIDTH(32), .AHB_DWIDTH(32), .LEN_W(4)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus));
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One full command: offers it, plays the AHB slave, consumes responses and
  // compares every observable against values computed from the transfer rules.
  task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input int len, input int err_beat, input int aws, input int dws,
                         input logic [31:0] wbase, input logic [31:0] winc,
                         input logic [31:0] rbase);
    logic [31:0] a, wd, exp_wd, rd, exp_rd, mask, repl;
    logic exp_err, exp_last;
    int step, stall;
    bit mis;
    step = 1 << size;
    mis  = (size == 2'd3) || ((addr % step) != 0);
    mask = (size == 2'd0) ? 32'h000000FF : (size == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
    repl = (size == 2'd0) ? 32'h01010101 : (size == 2'd1) ? 32'h00010001 : 32'h00000001;

    @(negedge HCLK);
    check_eq("cmd_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
    bus.cmd_size = size; bus.cmd_len = 4'(len);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom;

    if (mis) begin
      check_eq("mis_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("mis_htrans", 32'(bus.HTRANS), 32'd0);
      check_eq("mis_err", 32'(bus.rsp_err), 32'd1);
      check_eq("mis_last", 32'(bus.rsp_last), 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge HCLK);
      bus.rsp_ready = 1'b0;
    end else begin
      for (int b = 0; b <= len; b++) begin
        a = addr + 32'(b * step);
        exp_wd = 32'd0;
        if (wr) begin
          check_eq("wr_ready", 32'(bus.wr_ready), 32'd1);
          wd = wbase + 32'(b) * winc;
          exp_wd = (wd & mask) * repl;
          bus.wr_valid = 1'b1; bus.wr_data = wd;
          @(negedge HCLK);
          bus.wr_valid = 1'b0; bus.wr_data = $urandom;
        end
        // address phase
        check_eq("htrans_nonseq", 32'(bus.HTRANS), 32'h2);
        check_eq("haddr", bus.HADDR, a);
        check_eq("hwrite", 32'(bus.HWRITE), 32'(wr));
        check_eq("hsize", 32'(bus.HSIZE), 32'(size));
        check_eq("hburst", 32'(bus.HBURST), 32'd0);
        stall = aws;
        bus.HREADY = 1'b0;
        for (int k = 0; k < stall; k++) begin
          @(negedge HCLK);
          check_eq("addr_hold_htrans", 32'(bus.HTRANS), 32'h2);
          check_eq("addr_hold_haddr", bus.HADDR, a);
        end
        bus.HREADY = 1'b1;
        @(negedge HCLK);
        // data phase
        check_eq("data_htrans", 32'(bus.HTRANS), 32'd0);
        check_eq("data_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        if (wr) check_eq("hwdata", bus.HWDATA, exp_wd);
        rd = rbase ^ (32'(b) * 32'h9E3779B9);
        if (b == err_beat) begin
          bus.HREADY = 1'b0; bus.HRESP = 2'b01;
          @(negedge HCLK);
          check_eq("err1_htrans", 32'(bus.HTRANS), 32'd0);
          check_eq("err1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
          bus.HREADY = 1'b1; bus.HRESP = 2'b01;
        end else begin
          bus.HREADY = 1'b0; bus.HRESP = 2'b00;
          for (int k = 0; k < dws; k++) begin
            @(negedge HCLK);
            check_eq("data_wait_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            if (wr) check_eq("hwdata_hold", bus.HWDATA, exp_wd);
          end
          bus.HREADY = 1'b1;
        end
        bus.HRDATA = rd;
        @(negedge HCLK);
        bus.HRESP = 2'b00; bus.HRDATA = $urandom;
        // response
        exp_err  = (b == err_beat);
        exp_last = (b == len) || exp_err;
        exp_rd   = wr ? 32'd0 : ((rd >> (8 * (a % 4))) & mask);
        check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        check_eq("rsp_last", 32'(bus.rsp_last), 32'(exp_last));
        stall = $urandom_range(2, 0);
        for (int k = 0; k < stall; k++) begin
          @(negedge HCLK);
          check_eq("rsp_hold_valid", 32'(bus.rsp_valid), 32'd1);
          check_eq("rsp_hold_rdata", bus.rsp_rdata, exp_rd);
        end
        bus.rsp_ready = 1'b1;
        @(negedge HCLK);
        bus.rsp_ready = 1'b0;
        if (exp_last) break;
      end
    end
    // back in IDLE with no further bus activity
    check_eq("end_busy", 32'(bus.busy), 32'd0);
    check_eq("end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("end_htrans", 32'(bus.HTRANS), 32'd0);
    check_eq("end_rsp_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  // Read stopped in ADDR (or DATA) and hit with an asynchronous reset.
  task automatic reset_mid(input bit in_data);
    @(negedge HCLK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h40;
    bus.cmd_size = 2'd2; bus.cmd_len = 4'd3;
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    check_eq("rst_pre_htrans", 32'(bus.HTRANS), 32'h2);
    bus.HREADY = in_data;
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    #2 HRESETN = 1'b0;
    #1;
    check_eq("rst_async_htrans", 32'(bus.HTRANS), 32'd0);
    check_eq("rst_async_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    HRESETN = 1'b1;
    @(negedge HCLK);
    check_eq("rst_after_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge HCLK);
    check_eq("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    int rl, re;
    HRESETN = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'd0;
    bus.cmd_size = 2'd0; bus.cmd_len = 4'd0;
    bus.wr_valid = 1'b0; bus.wr_data = 32'd0; bus.rsp_ready = 1'b0;
    bus.HRDATA = 32'd0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
    #12;
    check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_htrans", 32'(bus.HTRANS), 32'd0);
    check_eq("rst_haddr", bus.HADDR, 32'd0);
    check_eq("rst_hwdata", bus.HWDATA, 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    check_eq("rst_timeout_flag", 32'(timeout_flag), 32'd0);
`endif
    @(negedge HCLK);
    HRESETN = 1'b1;

    // directed cases
    run_cmd(1'b1, 32'h100, 2'd2, 0, -1, 0, 0, 32'hDEADBEEF, 32'd0, 32'd0);
    run_cmd(1'b0, 32'h204, 2'd0, 0, -1, 3, 0, 32'd0, 32'd0, 32'h11223344);
    run_cmd(1'b0, 32'h207, 2'd0, 0, -1, 0, 0, 32'd0, 32'd0, 32'h11223344);
    run_cmd(1'b1, 32'h002, 2'd1, 2, -1, 0, 0, 32'h0000A5A5, 32'd0, 32'd0);
    run_cmd(1'b0, 32'h300, 2'd2, 3, 1, 0, 1, 32'd0, 32'd0, 32'hCAFEF00D);
    run_cmd(1'b0, 32'h003, 2'd2, 0, -1, 0, 0, 32'd0, 32'd0, 32'd0);
    run_cmd(1'b1, 32'hFFFFFFFE, 2'd1, 1, -1, 1, 1, 32'h1234, 32'h1111, 32'd0);
    run_cmd(1'b0, 32'h10, 2'd3, 2, -1, 0, 0, 32'd0, 32'd0, 32'd0);
    reset_mid(1'b1);
    reset_mid(1'b0);

    // randomized commands
    for (int n = 0; n < 40; n++) begin
      rs = 2'($urandom_range(3, 0));
      ra = $urandom;
      if (($urandom % 8) == 0) ra = 32'hFFFFFFF0 | (ra & 32'h0000000F);
      if ((rs != 2'd3) && (($urandom % 4) != 0)) ra = ra & ~((32'd1 << rs) - 32'd1);
      rl = $urandom_range(15, 0);
      re = (($urandom % 4) == 0) ? $urandom_range(rl, 0) : -1;
      run_cmd(1'($urandom), ra, rs, rl, re, $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom, $urandom, $urandom);
    end

`ifdef AHBL_CMD_MASTER_TIMEOUT_EN
    begin
      bit seen;
      int cyc;
      @(negedge HCLK);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h80;
      bus.cmd_size = 2'd2; bus.cmd_len = 4'd5;
      @(negedge HCLK);
      bus.cmd_valid = 1'b0;
      check_eq("to_htrans", 32'(bus.HTRANS), 32'h2);
      bus.HREADY = 1'b0;
      seen = 1'b0; cyc = 0;
      for (int k = 1; k <= TO + 4 && !seen; k++) begin
        @(negedge HCLK);
        if (bus.rsp_valid) begin seen = 1'b1; cyc = k; end
      end
      check_eq("to_seen", 32'(seen), 32'd1);
      check_eq("to_cycles", 32'(cyc), 32'(TO));
      check_eq("to_err", 32'(bus.rsp_err), 32'd1);
      check_eq("to_last", 32'(bus.rsp_last), 32'd1);
      check_eq("to_resp_htrans", 32'(bus.HTRANS), 32'd0);
      check_eq("to_flag", 32'(timeout_flag), 32'd1);
      bus.HREADY = 1'b1; bus.rsp_ready = 1'b1;
      @(negedge HCLK);
      bus.rsp_ready = 1'b0;
      check_eq("to_end_busy", 32'(bus.busy), 32'd0);
      check_eq("to_flag_sticky", 32'(timeout_flag), 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahbl_cmd_master.md
Name: ahbl_cmd_master

Overview:
- AHB-Lite initiator that turns simple command/write-data/response handshakes into AHB-Lite single transfers.
- It drives the slave side of the fabric SRAM AHB interface, e.g. from the UART command bridge or the bootloader copy engine.
- One transfer is outstanding at a time: address phase, then data phase, then response. There is no pipelining.
- A command covers 1..16 beats with an incrementing address. Each beat is an independent NONSEQ/SINGLE transfer.

Parameters:
- AHB_AWIDTH, 32, address width.
- AHB_DWIDTH, 32, data width; only 32 is supported.
- LEN_W, 4, width of cmd_len; a command is cmd_len+1 beats.
- TIMEOUT_CYCLES, 1024, wait-state limit; used only with the optional feature.

Ports:
- HCLK  in  1  clock.
- HRESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when valid&ready; high only in IDLE.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  AHB_AWIDTH  start byte address.
- cmd_size  in  2  0=byte, 1=half, 2=word; 3 is illegal.
- cmd_len  in  LEN_W  beats minus one.
- wr_valid  in  1  write data offered.
- wr_ready  out  1  write data accepted.
- wr_data  in  32  right-justified write data.
- rsp_valid  out  1  per-beat response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  right-justified, zero-extended read data; 0 for writes.
- rsp_err  out  1  beat failed.
- rsp_last  out  1  final response of the command.
- busy  out  1  state is not IDLE.
- HADDR  out  AHB_AWIDTH  address.
- HTRANS  out  2  IDLE=00 or NONSEQ=10 only.
- HWRITE  out  1  write.
- HSIZE  out  3  {0,cmd_size}.
- HBURST  out  3  constant 000 (SINGLE).
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  bus ready.
- HRESP  in  2  bit0=ERROR.

Behaviour:
- Reset values: all outputs are 0, state IDLE, cmd_ready=1 on the first clock after reset release.
- HRESETN is asynchronous. Asserting it mid-transfer forces IDLE and HTRANS=00 immediately. No response is emitted for the aborted command.

Command capture:
- IDLE accepts a command and latches addr, size, write and remaining-beat count.
- A misaligned address (size1 with addr[0]=1, size2 with addr[1:0]!=0) or size==3 does not touch the bus. The block goes straight to RESP with rsp_err=1 and rsp_last=1.

States:
- IDLE.
- WDATA (write only): wr_ready=1. On wr_valid, latch wr_data replicated across lanes: byte -> 4 copies, half -> 2 copies, word as-is. Then go to ADDR. Read commands skip WDATA.
- ADDR: drive HTRANS=10 with HADDR/HWRITE/HSIZE. Hold all of them while HREADY=0. On HREADY=1 go to DATA.
- DATA: HTRANS=00; HWDATA holds the latched data for the whole phase.
  - HREADY=0 with HRESP=ERROR is the first error cycle: hold.
  - On HREADY=1, record err=HRESP[0].
  - For a read, extract the lane: byte = HRDATA >> (8*addr[1:0]) masked to 8 bits; half = HRDATA >> (8*addr[1:0]) masked to 16 bits.
  - Go to RESP.
- RESP: rsp_valid=1, outputs stable until rsp_ready.
  - rsp_last = (remaining==0) | err.
  - On handshake: if rsp_last go to IDLE. Otherwise addr += (1<<size), remaining -= 1, and go to WDATA or ADDR.
  - An error therefore abandons the remaining beats.

Timing and invariants:
- Minimum beat latency with zero wait states: ADDR 1 cycle + DATA 1 cycle + RESP 1 cycle, with rsp_ready already high. Each wait state adds 1 cycle.
- Address increments wrap modulo 2^AHB_AWIDTH with no boundary check.
- HTRANS is never NONSEQ outside ADDR. HMASTLOCK is not driven.

Optional Feature:
- Macro AHBL_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive HREADY=0 cycles in ADDR or DATA.
  - When it reaches TIMEOUT_CYCLES, go to RESP with rsp_err=1 and rsp_last=1, HTRANS=00, and clear the counter.
  - A sticky output timeout_flag (1 bit, cleared only by reset) is added.
- Undefined: no counter and no timeout_flag port; the block waits indefinitely.

Test Plan:
- Word write: addr 0x100, data 0xDEADBEEF, HREADY always 1 -> one NONSEQ cycle with HADDR=0x100, HSIZE=010; the next cycle HWDATA=0xDEADBEEF; rsp_err=0, rsp_last=1.
- Read with 3 wait states: addr 0x204, size byte, HRDATA=0x11223344 -> HADDR held 4 cycles; rsp_rdata=0x00000044; then a byte read at 0x207 -> 0x00000011.
- Half write at 0x002, len=2 (3 beats), wr_data 0xA5A5 -> HADDR 0x002, 0x004, 0x006; HWDATA=0xA5A5A5A5; 3 responses, rsp_last only on the third.
- ERROR on beat 2 of a 4-beat read: HRESP=ERROR with HREADY 0 then 1 -> beat-2 response has rsp_err=1 and rsp_last=1; no third NONSEQ issued.
- Misaligned word read at 0x003 -> no HTRANS activity; rsp_err=1, rsp_last=1. Reset asserted mid-DATA -> HTRANS=00 and busy=0 asynchronously.
- With AHBL_CMD_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, HREADY stuck at 0 -> rsp_err=1 after 8 stalled cycles; timeout_flag=1.
